// File: rtl/trace_packer.sv
// rtl/trace_packer.sv - packs kept trace instructions into gap/loss-tagged items behind an FWFT FIFO
module trace_packer #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int GAP_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int OVF_WIDTH   = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          pc_valid,
    input  logic [PC_WIDTH-1:0]                           pc,
    input  logic [INSTR_WIDTH-1:0]                        instr,
    input  logic                                          drop_instr,
    output logic [1+GAP_WIDTH+INSTR_WIDTH+PC_WIDTH-1:0]   m_tdata,
    output logic                                          m_tvalid,
    input  logic                                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]                   fifo_level,
    output logic [OVF_WIDTH-1:0]                          overflow_count
);

    localparam int DW = 1 + GAP_WIDTH + INSTR_WIDTH + PC_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [DW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic                 lost_pending_q, lost_pending_d;
    logic [OVF_WIDTH-1:0] ovf_q, ovf_d;

    logic          keep_ev;
    logic          skip_ev;
    logic          pop;
    logic          push;
    logic          lost;
    logic [DW-1:0] item;

    always_comb begin
        keep_ev = pc_valid && !drop_instr;
        skip_ev = pc_valid && drop_instr;
        pop     = (level_q != '0) && m_tready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push    = keep_ev && ((level_q != FULL_LEVEL) || pop);
        lost    = keep_ev && !push;
        item    = {lost_pending_q, gap_q, instr, pc};
    end

    always_comb begin
        wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d        = level_q;
        gap_d          = gap_q;
        lost_pending_d = lost_pending_q;
        ovf_d          = ovf_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A lost keep is accounted for as a skipped instruction in the next item's gap.
        if (push) begin
            gap_d          = '0;
            lost_pending_d = 1'b0;
        end else if ((skip_ev || lost) && !(&gap_q)) begin
            gap_d = gap_q + 1'b1;
        end

        if (lost) begin
            lost_pending_d = 1'b1;
            if (!(&ovf_q)) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            gap_q          <= '0;
            lost_pending_q <= 1'b0;
            ovf_q          <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            gap_q          <= gap_d;
            lost_pending_q <= lost_pending_d;
            ovf_q          <= ovf_d;
        end
    end

    // Storage needs no reset: the level counter alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= item;
        end
    end

    assign m_tdata        = mem_q[rd_ptr_q];
    assign m_tvalid       = (level_q != '0);
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// tb/tb_trace_packer.sv - self-checking bench for trace_packer
module tb_trace_packer;

    localparam int PCW   = 64;
    localparam int IW    = 32;
    localparam int GW    = 16;
    localparam int DEPTH = 8;
    localparam int OW    = 32;
    localparam int DW    = 1 + GW + IW + PCW;
    localparam int DW4   = 1 + 4 + IW + PCW;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst_n;
    logic           pc_valid;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
    logic           drop_instr;
    logic           m_tready;

    logic [DW-1:0]  m_tdata;
    logic           m_tvalid;
    logic [LW-1:0]  fifo_level;
    logic [OW-1:0]  overflow_count;

    logic [DW4-1:0] m_tdata4;
    logic           m_tvalid4;
    logic [LW-1:0]  fifo_level4;
    logic [OW-1:0]  overflow_count4;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [DW-1:0] mq [$];
    longint unsigned m_gap;
    bit              m_loss;
    longint unsigned m_ovf;

    trace_packer #(
        .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .GAP_WIDTH(GW), .FIFO_DEPTH(DEPTH), .OVF_WIDTH(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .drop_instr(drop_instr), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fifo_level(fifo_level), .overflow_count(overflow_count)
    );

    trace_packer #(
        .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .GAP_WIDTH(4), .FIFO_DEPTH(DEPTH), .OVF_WIDTH(OW)
    ) dut_g4 (
        .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .drop_instr(drop_instr), .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready),
        .fifo_level(fifo_level4), .overflow_count(overflow_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", pass_cnt, check_cnt);
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk(input logic loss, input logic [GW-1:0] gap,
                                         input logic [IW-1:0] ins, input logic [PCW-1:0] p);
        return {loss, gap, ins, p};
    endfunction

    function automatic logic [IW-1:0] ins_of(input logic [PCW-1:0] p);
        return p[IW-1:0] ^ 32'hA5A5_3C00;
    endfunction

    task automatic cyc(input logic v, input logic d, input logic [PCW-1:0] p,
                       input logic [IW-1:0] i, input logic r);
        pc_valid   = v;
        drop_instr = d;
        pc         = p;
        instr      = i;
        m_tready   = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        pc_valid = 1'b0; drop_instr = 1'b0; pc = '0; instr = '0; m_tready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Queue-based reference: applies one cycle of inputs to the expected item stream.
    task automatic model_step(input logic v, input logic d, input logic [PCW-1:0] p,
                              input logic [IW-1:0] i, input logic r);
        bit popping;
        bit room;
        popping = (mq.size() != 0) && r;
        room    = (mq.size() < DEPTH) || popping;
        if (popping) void'(mq.pop_front());
        if (v && !d && room) begin
            mq.push_back(mk(m_loss, GW'(m_gap), i, p));
            m_gap  = 0;
            m_loss = 0;
        end else if (v) begin
            if (!d) begin
                m_loss = 1;
                if (m_ovf < 64'hFFFF_FFFF) m_ovf++;
            end
            if (m_gap < 64'hFFFF) m_gap++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_valid = 1'b0; drop_instr = 1'b0; pc = '0; instr = '0; m_tready = 1'b0;
        #1;
        check_cnt++;
        if (m_tvalid !== 1'b0 || fifo_level !== '0 || overflow_count !== '0)
            $display("FAIL reset_initial: tvalid=%b level=%0d ovf=%0d, need 0/0/0", m_tvalid, fifo_level, overflow_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 0, 64'h10, ins_of(64'h10), 0);
        cyc(1, 1, 64'h14, ins_of(64'h14), 0);
        cyc(1, 0, 64'h18, ins_of(64'h18), 0);
        cyc(1, 1, 64'h1c, ins_of(64'h1c), 0);
        cyc(1, 0, 64'h20, ins_of(64'h20), 0);
        check_cnt++;
        if (fifo_level !== LW'(3)) $display("FAIL reset_prefill_level: level=%0d need 3", fifo_level);
        else pass_cnt++;
        pc_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (m_tvalid !== 1'b0 || fifo_level !== '0 || overflow_count !== '0)
            $display("FAIL reset_async: tvalid=%b level=%0d ovf=%0d, need 0/0/0", m_tvalid, fifo_level, overflow_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 64'h24, ins_of(64'h24), 0);
        cyc(0, 0, 64'h0, 32'h0, 0);
        cyc(1, 0, 64'h40, ins_of(64'h40), 0);
        check_cnt++;
        if (m_tvalid !== 1'b1 || m_tdata !== mk(0, 16'd1, ins_of(64'h40), 64'h40))
            $display("FAIL reset_first_item: tvalid=%b data=%h need %h", m_tvalid, m_tdata, mk(0, 16'd1, ins_of(64'h40), 64'h40));
        else pass_cnt++;
    endtask

    task automatic test_gap_count();
        do_reset();
        cyc(1, 0, 64'h100, ins_of(64'h100), 1);
        check_cnt++;
        if (m_tvalid !== 1'b1 || m_tdata !== mk(0, 0, ins_of(64'h100), 64'h100))
            $display("FAIL gap_first_item: tvalid=%b data=%h need %h", m_tvalid, m_tdata, mk(0, 0, ins_of(64'h100), 64'h100));
        else pass_cnt++;
        for (int k = 0; k < 5; k++) cyc(1, 1, 64'h104 + 64'(4 * k), 32'h0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 64'h0, 32'h0, 1);
        check_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL gap_empty_before_keep: tvalid=%b need 0", m_tvalid);
        else pass_cnt++;
        cyc(1, 0, 64'h118, ins_of(64'h118), 1);
        check_cnt++;
        if (m_tvalid !== 1'b1 || m_tdata !== mk(0, 5, ins_of(64'h118), 64'h118))
            $display("FAIL gap_second_item: tvalid=%b data=%h need %h", m_tvalid, m_tdata, mk(0, 5, ins_of(64'h118), 64'h118));
        else pass_cnt++;
        cyc(0, 0, 64'h0, 32'h0, 1);
        check_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL gap_drained: tvalid=%b need 0", m_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1, 0, 64'(k), ins_of(64'(k)), 0);
        check_cnt++;
        if (fifo_level !== LW'(8) || overflow_count !== 32'd2)
            $display("FAIL ovf_counts: level=%0d ovf=%0d need 8/2", fifo_level, overflow_count);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            check_cnt++;
            if (m_tvalid !== 1'b1 || m_tdata !== mk(0, 0, ins_of(64'(k)), 64'(k)))
                $display("FAIL ovf_drain_%0d: tvalid=%b data=%h need %h", k, m_tvalid, m_tdata, mk(0, 0, ins_of(64'(k)), 64'(k)));
            else pass_cnt++;
            cyc(0, 0, 64'h0, 32'h0, 1);
        end
        check_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL ovf_drained: tvalid=%b need 0", m_tvalid);
        else pass_cnt++;
        cyc(1, 0, 64'h55, ins_of(64'h55), 1);
        check_cnt++;
        if (m_tdata !== mk(1, 2, ins_of(64'h55), 64'h55) || overflow_count !== 32'd2)
            $display("FAIL ovf_loss_item: data=%h ovf=%0d need %h/2", m_tdata, overflow_count, mk(1, 2, ins_of(64'h55), 64'h55));
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1, 0, 64'h200 + 64'(k), ins_of(64'h200 + 64'(k)), 0);
        cyc(1, 0, 64'h2ff, ins_of(64'h2ff), 1);
        check_cnt++;
        if (fifo_level !== LW'(8) || overflow_count !== 32'd0 || m_tdata !== mk(0, 0, ins_of(64'h201), 64'h201))
            $display("FAIL fullpop_state: level=%0d ovf=%0d data=%h need 8/0/%h", fifo_level, overflow_count, m_tdata, mk(0, 0, ins_of(64'h201), 64'h201));
        else pass_cnt++;
        for (int k = 0; k < 7; k++) cyc(0, 0, 64'h0, 32'h0, 1);
        check_cnt++;
        if (fifo_level !== LW'(1) || m_tdata !== mk(0, 0, ins_of(64'h2ff), 64'h2ff))
            $display("FAIL fullpop_tail: level=%0d data=%h need 1/%h", fifo_level, m_tdata, mk(0, 0, ins_of(64'h2ff), 64'h2ff));
        else pass_cnt++;
    endtask

    task automatic test_gap_saturation();
        logic [DW4-1:0] exp4;
        do_reset();
        for (int k = 0; k < 20; k++) cyc(1, 1, 64'h280 + 64'(k), 32'h0, 0);
        cyc(1, 0, 64'h300, ins_of(64'h300), 0);
        exp4 = {1'b0, 4'hF, ins_of(64'h300), 64'h300};
        check_cnt++;
        if (m_tvalid4 !== 1'b1 || m_tdata4 !== exp4)
            $display("FAIL gap_sat_g4: tvalid=%b data=%h need %h", m_tvalid4, m_tdata4, exp4);
        else pass_cnt++;
        check_cnt++;
        if (m_tdata !== mk(0, 16'd20, ins_of(64'h300), 64'h300))
            $display("FAIL gap_nosat_g16: data=%h need %h", m_tdata, mk(0, 16'd20, ins_of(64'h300), 64'h300));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 64'h400 + 64'(8 * k), ins_of(64'h400 + 64'(8 * k)), 1);
            check_cnt++;
            if (m_tvalid !== 1'b1 || fifo_level !== LW'(1) || m_tdata !== mk(0, 0, ins_of(64'h400 + 64'(8 * k)), 64'h400 + 64'(8 * k)))
                $display("FAIL b2b_%0d: tvalid=%b level=%0d data=%h", k, m_tvalid, fifo_level, m_tdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int              events;
        int              cycles;
        longint unsigned sum;
        bit              stall;
        logic [DW-1:0]   prev;
        logic            v, d, r;
        logic [PCW-1:0]  p;
        logic [IW-1:0]   i;
        events = 0; cycles = 0; sum = 0;
        do_reset();
        mq.delete(); m_gap = 0; m_loss = 0; m_ovf = 0;
        while (events <= 1000 && cycles < 5000) begin
            v = ($urandom_range(99) < 85);
            d = ($urandom_range(99) < 30);
            r = ($urandom_range(99) < 40);
            p = {$urandom, $urandom};
            i = $urandom;
            if (events == 1000) begin
                v = 1'b1; d = 1'b0; r = 1'b1;
            end
            if (v) events++;
            if (m_tvalid && r) sum += longint'(m_tdata[PCW+IW +: GW]) + 1;
            stall = m_tvalid && !r;
            prev  = m_tdata;
            model_step(v, d, p, i, r);
            cyc(v, d, p, i, r);
            cycles++;
            if (stall) begin
                check_cnt++;
                if (m_tdata !== prev) $display("FAIL rnd_stall_hold: data=%h need %h", m_tdata, prev);
                else pass_cnt++;
            end
            check_cnt++;
            if (m_tvalid !== (mq.size() != 0) || fifo_level !== LW'(mq.size()) || overflow_count !== OW'(m_ovf))
                $display("FAIL rnd_status: tvalid=%b level=%0d ovf=%0d need %0d/%0d", m_tvalid, fifo_level, overflow_count, mq.size(), m_ovf);
            else pass_cnt++;
            if (mq.size() != 0) begin
                check_cnt++;
                if (m_tdata !== mq[0]) $display("FAIL rnd_head: data=%h need %h", m_tdata, mq[0]);
                else pass_cnt++;
            end
        end
        for (int k = 0; k < 20 && m_tvalid; k++) begin
            sum += longint'(m_tdata[PCW+IW +: GW]) + 1;
            model_step(0, 0, '0, '0, 1);
            cyc(0, 0, '0, '0, 1);
        end
        check_cnt++;
        if (m_tvalid !== 1'b0) $display("FAIL rnd_drain_timeout: tvalid=%b need 0", m_tvalid);
        else pass_cnt++;
        check_cnt++;
        if (sum != longint'(events)) $display("FAIL rnd_gap_sum: sum=%0d need %0d", sum, events);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_gap_count();
        test_overflow();
        test_full_pop();
        test_gap_saturation();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
